alu_seq_unit: RTL and testbench

- Parametrised, registered ALU with a valid/ready handshake on both sides; the next generation of the team's 32-bit combinational ALU.
- Single-cycle ops: AND, OR, XOR, NOR, ADD, SUB, SLT.
- Iterative unsigned multiply: shift-add, one partial product per cycle, full 2*WIDTH-bit product.
- Sits between the register-read stage and writeback; back-pressure holds the result until the consumer takes it.

---
 rtl/alu_seq_unit.sv | 165 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with valid/ready handshakes on both sides.
//   Single-cycle ops (AND, OR, XOR, NOR, ADD, SUB, SLT) have a latency of one cycle.
//   MUL is an iterative shift-add multiply that produces the full 2*WIDTH-bit product.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid / in_ready   upstream handshake for a, b, op
//   out_valid / out_ready downstream handshake for result, result_hi and the flags
//   result, result_hi     low word / high word (high word is nonzero only for MUL)
//   cout, overflow        adder carry (MUL: result_hi != 0) / signed overflow of ADD and SUB
//   zero, set             (a - b) == 0 and signed a < b, computed for every op
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             set
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t                 state, state_nx;
  logic                   alive;
  logic [WIDTH-1:0]       mcand, mplier;
  logic [2*WIDTH-1:0]     acc, addend;
  logic [CNTW-1:0]        cnt;
  logic                   zero_m, set_m;

  logic                   accept, mul_last, done_load;
  logic [WIDTH-1:0]       b_op, sum, diff, res_nx;
  logic                   carry, add_ovf, sub_ovf, lt, eq;

  // The add/sub path inverts b and injects a carry for op[2]=1 (SUB, SLT).
  always_comb begin
    b_op          = op[2] ? ~b : b;
    {carry, sum}  = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, op[2]};
    add_ovf       = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Separate comparator so zero/set are valid for every op, not only SUB/SLT.
  always_comb begin
    diff    = a - b;
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    lt      = diff[WIDTH-1] ^ sub_ovf;
    eq      = (diff == '0);
  end

  always_comb begin
    res_nx = '0;
    case (op)
      OP_AND:  res_nx = a & b;
      OP_OR:   res_nx = a | b;
      OP_ADD:  res_nx = sum;
      OP_XOR:  res_nx = a ^ b;
      OP_NOR:  res_nx = ~(a | b);
      OP_SUB:  res_nx = sum;
      OP_SLT:  res_nx = {{(WIDTH-1){1'b0}}, lt};
      default: res_nx = '0;
    endcase
  end

  // alive is cleared by reset so in_ready stays low until the first edge after release.
  assign in_ready  = alive && (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_last  = (state == S_MUL) && (cnt == CNTW'(WIDTH - 1));
  assign done_load = (state == S_DONE) && (!out_valid || out_ready);
  assign addend    = {{WIDTH{1'b0}}, mcand} << cnt;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && op == OP_MUL) state_nx = S_MUL;
      S_MUL:   if (mul_last) state_nx = S_DONE;
      S_DONE:  if (done_load) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
    end
  end

  // Multiply datapath; zero/set of the accepted operands are parked until DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      zero_m <= 1'b0;
      set_m  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept && op == OP_MUL) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
        zero_m <= eq;
        set_m  <= lt;
      end
    end else if (state == S_MUL) begin
      if (mplier[0]) acc <= acc + addend;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      set       <= 1'b0;
    end else if (accept && op != OP_MUL) begin
      out_valid <= 1'b1;
      result    <= res_nx;
      result_hi <= '0;
      cout      <= carry;
      overflow  <= (op == OP_ADD || op == OP_SUB) ? add_ovf : 1'b0;
      zero      <= eq;
      set       <= lt;
    end else if (done_load) begin
      out_valid <= 1'b1;
      result    <= acc[WIDTH-1:0];
      result_hi <= acc[2*WIDTH-1:WIDTH];
      cout      <= |acc[2*WIDTH-1:WIDTH];
      overflow  <= 1'b0;
      zero      <= zero_m;
      set       <= set_m;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, result, result_hi;
  logic [2:0]    op;
  logic          cout, overflow, zero, set;

  int total = 0;
  int bad   = 0;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .cout(cout), .overflow(overflow),
    .zero(zero), .set(set)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         c, v, z, s;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic seen;

    //          op      a             b             result        c     v     z     s
    vt[0]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{3'b111, 32'hFFFFFFFD, 32'h00000002, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{3'b000, 32'h000000F0, 32'h0000000F, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{3'b001, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{3'b100, 32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{3'b101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{3'b111, 32'h00000002, 32'hFFFFFFFD, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[11] = '{3'b010, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held with in_valid asserted
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    op = 3'b010; a = 32'h11; b = 32'h22;
    #2;
    chk("rst_in_ready", in_ready, 0);
    tick(); tick();
    chk("rst_outs", {out_valid, result, cout, overflow, zero, set}, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_in_ready2", in_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    chk("no_accept_in_reset", out_valid, 0);

    // Back-to-back single-cycle ops, one result per cycle
    for (int i = 0; i < 12; i++) begin
      op = vt[i].op; a = vt[i].a; b = vt[i].b; in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_result", i), result, vt[i].res);
      chk($sformatf("v%0d_hi", i), result_hi, 0);
      chk($sformatf("v%0d_flags", i), {cout, overflow, zero, set},
          {vt[i].c, vt[i].v, vt[i].z, vt[i].s});
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    // MUL 0xFFFFFFFF * 2
    op = 3'b011; a = 32'hFFFFFFFF; b = 32'h2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) seen = 1'b1;
      tick();
      n++;
    end
    chk("mul_latency", n, W + 1);
    chk("mul_in_ready_low", seen, 0);
    chk("mul_lo", result, 32'hFFFFFFFE);
    chk("mul_hi", result_hi, 32'h1);
    chk("mul_flags", {cout, overflow, zero, set}, 4'b1001);
    tick();
    chk("mul_consumed", out_valid, 0);

    // Back-pressure: ADD held, queued OR accepted on release
    out_ready = 1'b0;
    op = 3'b010; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    tick();
    op = 3'b001; a = 32'hF0; b = 32'h0F;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (result !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("bp_hold", seen, 0);
    chk("bp_result", result, 32'd30);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_or_valid", out_valid, 1);
    chk("bp_or_result", result, 32'hFF);
    tick();
    chk("bp_drain", out_valid, 0);

    // Reset in the middle of a multiply
    op = 3'b011; a = 32'd7; b = 32'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);
    chk("midrst_idle", in_ready, 1);

    op = 3'b011; a = 32'd7; b = 32'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("mul2_latency", n, W + 1);
    chk("mul2_lo", result, 32'd63);
    chk("mul2_hi", result_hi, 0);
    chk("mul2_flags", {cout, overflow, zero, set}, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
